// File: rtl/pwm_peripheral_if.sv
// Register-file side of the PWM peripheral: enables, mode selects and requested duty.
// The register file drives through master; the PWM block reads through slave.
interface pwm_peripheral_if #(
  parameter int PWM_BITS = 8
);
  logic [7:0]          en_reg_out_7_0;
  logic [7:0]          en_reg_out_15_8;
  logic [7:0]          en_reg_pwm_7_0;
  logic [7:0]          en_reg_pwm_15_8;
  logic [PWM_BITS-1:0] pwm_duty_cycle;

  modport master (
    output en_reg_out_7_0,
    output en_reg_out_15_8,
    output en_reg_pwm_7_0,
    output en_reg_pwm_15_8,
    output pwm_duty_cycle
  );

  modport slave (
    input en_reg_out_7_0,
    input en_reg_out_15_8,
    input en_reg_pwm_7_0,
    input en_reg_pwm_15_8,
    input pwm_duty_cycle
  );
endinterface

// File: rtl/pwm_peripheral.sv
// Sixteen registered output pins, each forced low, static high or driven by one shared
// PWM waveform whose duty is double-buffered at the period wrap.
module pwm_peripheral #(
  parameter int CLK_DIV  = 3000,
  parameter int PWM_BITS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  pwm_peripheral_if.slave    regs,
  output logic [15:0]        out,
  output logic               pwm_tick
);

  localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(CLK_DIV - 1);
  localparam logic [PWM_BITS-1:0] CNT_LAST   = {PWM_BITS{1'b1}};

  logic [PRESC_W-1:0]  presc_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_shadow;
  logic                tick;
  logic                period_wrap;
  logic                pwm_lvl;
  logic [15:0]         en_out;
  logic [15:0]         en_pwm;
  logic [15:0]         out_nxt;

  // All-ones duty is a true 100 %; zero duty never produces a sliver at the wrap.
  function automatic logic pwm_level(input logic [PWM_BITS-1:0] cnt,
                                     input logic [PWM_BITS-1:0] duty);
    if (duty == CNT_LAST) return 1'b1;
    return (cnt < duty);
  endfunction

  assign tick        = (presc_cnt == PRESC_LAST);
  assign period_wrap = tick && (pwm_cnt == CNT_LAST);
  assign pwm_lvl     = pwm_level(pwm_cnt, duty_shadow);

  assign en_out  = {regs.en_reg_out_15_8, regs.en_reg_out_7_0};
  assign en_pwm  = {regs.en_reg_pwm_15_8, regs.en_reg_pwm_7_0};
  assign out_nxt = en_out & (~en_pwm | {16{pwm_lvl}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Requested duty is only sampled at the period boundary, so a write never cuts a period short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow <= '0;
    end else if (period_wrap) begin
      duty_shadow <= regs.pwm_duty_cycle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out      <= '0;
      pwm_tick <= 1'b0;
    end else begin
      out      <= out_nxt;
      pwm_tick <= tick;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral with CLK_DIV=4, PWM_BITS=8 (1024-clock PWM period).
module tb_pwm_peripheral;
  localparam int CLK_DIV  = 4;
  localparam int PWM_BITS = 8;
  localparam int STEPS    = 256;
  localparam int PERIOD   = CLK_DIV * STEPS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] out;
  logic        pwm_tick;

  pwm_peripheral_if #(.PWM_BITS(PWM_BITS)) regs ();

  pwm_peripheral #(.CLK_DIV(CLK_DIV), .PWM_BITS(PWM_BITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .regs     (regs),
    .out      (out),
    .pwm_tick (pwm_tick)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference: n = clock edges since reset release; everything else follows by arithmetic.
  int          n = 0;
  int          shadow = 0;
  logic [15:0] exp_out = '0;
  logic        exp_tick = 1'b0;

  task automatic set_regs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    regs.en_reg_out_7_0  = eo[7:0];
    regs.en_reg_out_15_8 = eo[15:8];
    regs.en_reg_pwm_7_0  = ep[7:0];
    regs.en_reg_pwm_15_8 = ep[15:8];
    regs.pwm_duty_cycle  = d;
  endtask

  task automatic step();
    int   stp;
    logic lvl;
    logic [15:0] eo;
    logic [15:0] ep;
    if (rst_n) begin
      stp = (n / CLK_DIV) % STEPS;
      lvl = (shadow == STEPS - 1) ? 1'b1 : (stp < shadow);
      eo  = {regs.en_reg_out_15_8, regs.en_reg_out_7_0};
      ep  = {regs.en_reg_pwm_15_8, regs.en_reg_pwm_7_0};
      exp_out  = eo & (~ep | {16{lvl}});
      exp_tick = ((n % CLK_DIV) == CLK_DIV - 1);
      if ((n % PERIOD) == PERIOD - 1) shadow = int'(regs.pwm_duty_cycle);
      n++;
    end else begin
      exp_out  = '0;
      exp_tick = 1'b0;
      n        = 0;
      shadow   = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_regs(16'hFFFF, 16'hFFFF, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (out !== 16'h0000) begin
        failures++;
        $display("FAIL reset_out: out=%h expected=0000", out);
      end
      checks++;
      if (pwm_tick !== 1'b0) begin
        failures++;
        $display("FAIL reset_tick: pwm_tick=%b expected=0", pwm_tick);
      end
    end
  endtask

  task automatic test_static();
    set_regs(16'h0000, 16'h0000, 8'h55);
    rst_n = 1'b1;
    step();
    set_regs(16'h00FF, 16'h0000, 8'h55);
    for (int i = 0; i < 24; i++) begin
      step();
      checks++;
      if (out !== 16'h00FF) begin
        failures++;
        $display("FAIL static_out: cycle=%0d out=%h expected=00ff", i, out);
      end
      checks++;
      if (pwm_tick !== exp_tick) begin
        failures++;
        $display("FAIL static_tick: cycle=%0d pwm_tick=%b expected=%b", i, pwm_tick, exp_tick);
      end
    end
  endtask

  task automatic test_half_duty();
    int hi;
    do_reset();
    set_regs(16'hFFFF, 16'hFFFF, 8'h80);
    while (n < PERIOD) begin
      step();
      checks++;
      if (out !== exp_out || pwm_tick !== exp_tick) begin
        failures++;
        $display("FAIL half_pre: n=%0d out=%h tick=%b expected=%h/%b", n, out, pwm_tick, exp_out, exp_tick);
      end
    end
    checks++;
    if (out !== 16'h0000) begin
      failures++;
      $display("FAIL half_before_first_load: out=%h expected=0000", out);
    end
    for (int p = 0; p < 2; p++) begin
      hi = 0;
      for (int i = 0; i < PERIOD; i++) begin
        step();
        checks++;
        if (out !== exp_out || (out !== 16'h0000 && out !== 16'hFFFF)) begin
          failures++;
          $display("FAIL half_wave: n=%0d out=%h expected=%h", n, out, exp_out);
        end
        if (i == 0) begin
          checks++;
          if (out !== 16'hFFFF) begin
            failures++;
            $display("FAIL half_rise_at_zero: out=%h expected=ffff", out);
          end
        end
        if (out[0]) hi++;
      end
      checks++;
      if (hi != 512) begin
        failures++;
        $display("FAIL half_high_time: period=%0d high=%0d expected=512", p, hi);
      end
    end
  endtask

  task automatic test_extremes();
    int bad;
    do_reset();
    set_regs(16'hFFFF, 16'hFFFF, 8'h00);
    bad = 0;
    for (int i = 0; i < 3 * PERIOD + 8; i++) begin
      step();
      if (out !== 16'h0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL duty_zero: high_cycles=%0d expected=0", bad);
    end
    do_reset();
    set_regs(16'hFFFF, 16'hFFFF, 8'hFF);
    while (n < PERIOD) step();
    bad = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      step();
      if (out !== 16'hFFFF) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL duty_full: low_cycles=%0d expected=0", bad);
    end
  endtask

  task automatic test_mid_change();
    int hi;
    do_reset();
    set_regs(16'hFFFF, 16'hFFFF, 8'h40);
    while (n < PERIOD) step();
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (n == PERIOD + 8'h10 * CLK_DIV) set_regs(16'hFFFF, 16'hFFFF, 8'hC0);
      step();
      checks++;
      if (out !== exp_out) begin
        failures++;
        $display("FAIL mid_wave: n=%0d out=%h expected=%h", n, out, exp_out);
      end
      if (out[5]) hi++;
    end
    checks++;
    if (hi != 256) begin
      failures++;
      $display("FAIL mid_current_period: high=%0d expected=256", hi);
    end
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step();
      if (out[5]) hi++;
    end
    checks++;
    if (hi != 768) begin
      failures++;
      $display("FAIL mid_next_period: high=%0d expected=768", hi);
    end
  endtask

  task automatic test_async_reset();
    int hi;
    do_reset();
    set_regs(16'hFFFF, 16'hFFFF, 8'h80);
    while (n < PERIOD + 8'h30 * CLK_DIV + 1) step();
    checks++;
    if (out !== 16'hFFFF) begin
      failures++;
      $display("FAIL areset_pre_high: out=%h expected=ffff", out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 16'h0000 || pwm_tick !== 1'b0) begin
      failures++;
      $display("FAIL areset_immediate: out=%h tick=%b expected=0000/0", out, pwm_tick);
    end
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    n      = 0;
    shadow = 0;
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step();
      if (out !== 16'h0000) hi++;
    end
    checks++;
    if (hi != 0) begin
      failures++;
      $display("FAIL areset_first_period: high=%0d expected=0", hi);
    end
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step();
      checks++;
      if (out !== exp_out) begin
        failures++;
        $display("FAIL areset_follow: n=%0d out=%h expected=%h", n, out, exp_out);
      end
      if (out[15]) hi++;
    end
    checks++;
    if (hi != 512) begin
      failures++;
      $display("FAIL areset_second_period: high=%0d expected=512", hi);
    end
  endtask

  task automatic test_random();
    do_reset();
    set_regs(16'($urandom), 16'($urandom), 8'($urandom));
    for (int i = 0; i < 4 * PERIOD; i++) begin
      if ($urandom_range(0, 15) == 0 || (n % PERIOD) == PERIOD - 1)
        set_regs(16'($urandom), 16'($urandom), 8'($urandom));
      step();
      checks++;
      if (out !== exp_out || pwm_tick !== exp_tick) begin
        failures++;
        $display("FAIL random: n=%0d out=%h tick=%b expected=%h/%b", n, out, pwm_tick, exp_out, exp_tick);
      end
    end
  endtask

  initial begin
    set_regs(16'h0000, 16'h0000, 8'h00);
    test_reset();
    test_static();
    test_half_duty();
    test_extremes();
    test_mid_change();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
